// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and widths for the async FIFO write-side arbiter.
// FIFO_DW tracks the FIFO data width so the arbiter data path always matches it.
package fifo_wr_arbiter_pkg;

  localparam int FIFO_DW    = 8;
  localparam int FIFO_DEPTH = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } wr_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr.sv
// Combinational round-robin pick: first set req bit searching upward from last_grant+1, mod NREQ.
// Zero latency; no flow control of its own.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int GW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   last_grant,
  output logic [GW-1:0]   gnt_idx,
  output logic            any_req
);

  logic [GW-1:0] idx;
  logic          found;

  // NREQ is a power of two, so the GW-bit add wraps exactly at NREQ.
  always_comb begin
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = last_grant + GW'(i);
      if (!found && req[idx]) begin
        gnt_idx = idx;
        found   = 1'b1;
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-based round-robin owner of the FIFO write port; 1-cycle arbitration, then one beat per cycle.
// fifo_full stalls the owner (no ready, no write, beat count frozen); grant ends on last or MAX_BURST.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int GW        = 2,
  parameter int DW        = FIFO_DW,
  parameter int MAX_BURST = 8,
  parameter int CW        = 4
) (
  input  logic             wr_clk,
  input  logic             wr_rstn,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]  req_last,
  output logic [NREQ-1:0]  req_ready,
  output logic             fifo_wr_en,
  output logic [DW-1:0]    fifo_wr_data,
  input  logic             fifo_full,
  output logic [GW-1:0]    grant_id,
  output logic             busy,
  output logic             forced_rot
);

  wr_state_e     state_q, state_d;
  logic [GW-1:0] grant_id_q, grant_id_d;
  logic [GW-1:0] last_grant_q, last_grant_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          forced_rot_q, forced_rot_d;

  logic [GW-1:0] arb_idx;
  logic          any_req;
  logic          own_vld, own_last, accept, hit_max, burst_end;
  logic [CW-1:0] beat_inc;

  rr_arbiter #(.NREQ(NREQ), .GW(GW)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .gnt_idx    (arb_idx),
    .any_req    (any_req)
  );

  assign own_vld   = req_valid[grant_id_q];
  assign own_last  = req_last[grant_id_q];
  assign accept    = (state_q == ST_BURST) && own_vld && !fifo_full;
  assign beat_inc  = beat_cnt_q + 1'b1;
  assign hit_max   = (beat_inc == CW'(MAX_BURST));
  assign burst_end = accept && (own_last || hit_max);

  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      state_q      <= ST_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= GW'(NREQ - 1);
      beat_cnt_q   <= '0;
      forced_rot_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      forced_rot_q <= forced_rot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_req)   state_d = ST_BURST;
      ST_BURST: if (burst_end) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    forced_rot_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (any_req) begin
        grant_id_d = arb_idx;
        beat_cnt_d = '0;
      end
    end else if (accept) begin
      beat_cnt_d = burst_end ? '0 : beat_inc;
      if (burst_end) last_grant_d = grant_id_q;
      // A beat that is both last and the MAX_BURST-th is a normal end, not a forced one.
      forced_rot_d = hit_max && !own_last;
    end
  end

  always_comb begin
    busy         = (state_q == ST_BURST);
    fifo_wr_en   = accept;
    fifo_wr_data = req_data[grant_id_q*DW +: DW];
    grant_id     = grant_id_q;
    forced_rot   = forced_rot_q;
    req_ready    = '0;
    if (busy && !fifo_full) req_ready[grant_id_q] = 1'b1;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: per-requester beat queues feed the DUT, accepted FIFO writes are logged and compared.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int GW   = 2;
  localparam int DW   = 8;

  logic              wr_clk;
  logic              wr_rstn;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_wr_data;
  logic              fifo_full;
  logic [GW-1:0]     grant_id;
  logic              busy;
  logic              forced_rot;

  fifo_wr_arbiter #(.NREQ(NREQ), .GW(GW), .DW(DW), .MAX_BURST(8), .CW(4)) dut (
    .wr_clk       (wr_clk),
    .wr_rstn      (wr_rstn),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_full    (fifo_full),
    .grant_id     (grant_id),
    .busy         (busy),
    .forced_rot   (forced_rot)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW:0]    rq [NREQ][$];
  logic [DW-1:0]  wq [$];
  logic [GW-1:0]  gq [$];
  int             cq [$];
  int             cyc = 0;
  int             frot_cnt = 0;

  logic [NREQ-1:0] s_pop;
  logic            s_wr;
  logic [DW-1:0]   s_d;
  logic [GW-1:0]   s_g;
  int              s_cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW:0] mk(input logic last, input logic [DW-1:0] d);
    return {last, d};
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() != 0) begin
        req_valid[i]          = 1'b1;
        req_last[i]           = rq[i][0][DW];
        req_data[i*DW +: DW]  = rq[i][0][DW-1:0];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  endtask

  // Called at negedge+2: samples just before the posedge, commits only edges taken out of reset.
  task automatic tick();
    #2;
    cyc++;
    if (forced_rot) frot_cnt++;
    s_pop = req_valid & req_ready;
    s_wr  = fifo_wr_en;
    s_d   = fifo_wr_data;
    s_g   = grant_id;
    s_cyc = cyc;
    @(posedge wr_clk);
    #1;
    if (wr_rstn) begin
      if (s_wr) begin
        wq.push_back(s_d);
        gq.push_back(s_g);
        cq.push_back(s_cyc);
      end
      for (int i = 0; i < NREQ; i++)
        if (s_pop[i]) void'(rq[i].pop_front());
    end
    drive();
    @(negedge wr_clk);
    #2;
  endtask

  task automatic wait_drain(input string tag);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0 &&
          rq[3].size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    int base;
    int f0;
    logic [DW-1:0] exp_d [$];
    wr_rstn   = 1'b0;
    fifo_full = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;

    // 1 + 3: reset with everyone requesting, then single-beat round robin
    for (int i = 0; i < NREQ; i++) begin
      rq[i].push_back(mk(1'b1, 8'h10 + 8'(i)));
      rq[i].push_back(mk(1'b1, 8'h20 + 8'(i)));
    end
    @(negedge wr_clk);
    #2;
    repeat (3) tick();
    chk("rst_valid_seen", 32'(req_valid), 32'hF);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    chk("rst_frot", 32'(forced_rot), 32'd0);
    wr_rstn = 1'b1;
    base = wq.size();
    wait_drain("rr_drain");
    chk("rr_count", 32'(wq.size() - base), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (base + k < wq.size()) begin
        chk("rr_grant", 32'(gq[base+k]), 32'(k % 4));
        chk("rr_data", 32'(wq[base+k]), 32'((k < 4 ? 8'h10 : 8'h20) + 8'(k % 4)));
        if (k > 0) chk("rr_spacing", 32'(cq[base+k] - cq[base+k-1]), 32'd2);
      end
    end

    // 2: req1 alone, 3-beat burst, cycle by cycle
    rq[1].push_back(mk(1'b0, 8'hA1));
    rq[1].push_back(mk(1'b0, 8'hA2));
    rq[1].push_back(mk(1'b1, 8'hA3));
    tick();
    chk("a_idle_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("a_idle_busy", 32'(busy), 32'd0);
    tick();
    chk("a1_wr_en", 32'(fifo_wr_en), 32'd1);
    chk("a1_data", 32'(fifo_wr_data), 32'hA1);
    chk("a1_grant", 32'(grant_id), 32'd1);
    chk("a1_ready", 32'(req_ready), 32'b0010);
    tick();
    chk("a2_wr_en", 32'(fifo_wr_en), 32'd1);
    chk("a2_data", 32'(fifo_wr_data), 32'hA2);
    tick();
    chk("a3_wr_en", 32'(fifo_wr_en), 32'd1);
    chk("a3_data", 32'(fifo_wr_data), 32'hA3);
    tick();
    chk("a_end_busy", 32'(busy), 32'd0);
    chk("a_end_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("a_end_frot", 32'(forced_rot), 32'd0);

    // 4: req0 4 beats, FIFO full for two cycles after beat 2
    base = wq.size();
    for (int k = 1; k <= 4; k++) rq[0].push_back(mk(k == 4, 8'hB0 + 8'(k)));
    tick();
    tick();
    chk("b1_data", 32'(fifo_wr_data), 32'hB1);
    tick();
    chk("b2_data", 32'(fifo_wr_data), 32'hB2);
    fifo_full = 1'b1;
    tick();
    chk("full1_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("full1_ready", 32'(req_ready), 32'd0);
    chk("full1_busy", 32'(busy), 32'd1);
    tick();
    chk("full2_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("full2_ready", 32'(req_ready), 32'd0);
    fifo_full = 1'b0;
    tick();
    chk("b3_data", 32'(fifo_wr_data), 32'hB3);
    chk("b3_ready", 32'(req_ready), 32'b0001);
    wait_drain("b_drain");
    chk("b_count", 32'(wq.size() - base), 32'd4);
    for (int k = 0; k < 4; k++)
      if (base + k < wq.size()) chk("b_fifo", 32'(wq[base+k]), 32'(8'hB1 + 8'(k)));

    // 5: req2 streams 12 beats past MAX_BURST while req3 waits
    base = wq.size();
    f0 = frot_cnt;
    for (int k = 1; k <= 12; k++) rq[2].push_back(mk(k == 12, 8'h40 + 8'(k)));
    rq[3].push_back(mk(1'b1, 8'h5D));
    exp_d.delete();
    for (int k = 1; k <= 8; k++) exp_d.push_back(8'h40 + 8'(k));
    exp_d.push_back(8'h5D);
    for (int k = 9; k <= 12; k++) exp_d.push_back(8'h40 + 8'(k));
    wait_drain("c_drain");
    chk("c_count", 32'(wq.size() - base), 32'd13);
    for (int k = 0; k < 13; k++)
      if (base + k < wq.size()) chk("c_order", 32'(wq[base+k]), 32'(exp_d[k]));
    if (base + 8 < wq.size()) chk("c_req3_grant", 32'(gq[base+8]), 32'd3);
    chk("c_frot_pulses", 32'(frot_cnt - f0), 32'd1);

    // 5b: exactly MAX_BURST beats with last on the final one ends normally
    base = wq.size();
    f0 = frot_cnt;
    for (int k = 1; k <= 8; k++) rq[1].push_back(mk(k == 8, 8'h60 + 8'(k)));
    wait_drain("g_drain");
    chk("g_count", 32'(wq.size() - base), 32'd8);
    chk("g_frot_pulses", 32'(frot_cnt - f0), 32'd0);

    // 6: reset during beat 3 of a req1 burst
    base = wq.size();
    for (int k = 1; k <= 5; k++) rq[1].push_back(mk(k == 5, 8'hE0 + 8'(k)));
    tick();
    tick();
    tick();
    tick();
    chk("e3_wr_en", 32'(fifo_wr_en), 32'd1);
    chk("e3_data", 32'(fifo_wr_data), 32'hE3);
    wr_rstn = 1'b0;
    #1;
    chk("mid_rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_grant", 32'(grant_id), 32'd0);
    @(negedge wr_clk);
    #2;
    rq[0].push_back(mk(1'b1, 8'hF1));
    tick();
    wr_rstn = 1'b1;
    wait_drain("e_drain");
    exp_d.delete();
    exp_d.push_back(8'hE1);
    exp_d.push_back(8'hE2);
    exp_d.push_back(8'hF1);
    exp_d.push_back(8'hE3);
    exp_d.push_back(8'hE4);
    exp_d.push_back(8'hE5);
    chk("e_count", 32'(wq.size() - base), 32'd6);
    for (int k = 0; k < 6; k++)
      if (base + k < wq.size()) chk("e_order", 32'(wq[base+k]), 32'(exp_d[k]));
    if (base + 2 < wq.size()) chk("e_post_rst_grant", 32'(gq[base+2]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares the single write port of the asynchronous FIFO among NREQ requesters in the write clock domain. Grants are round-robin and burst-based: one requester owns the port until its last beat is accepted or MAX_BURST beats have been written. It sits directly in front of the FIFO write side. It drives wr_en/wr_data and uses fifo_full as backpressure.

Parameters:
NREQ, 4, number of requesters (power of two, 2..8)
GW, 2, grant index width = log2(NREQ)
DW, 8, data width; equals the FIFO data width define
MAX_BURST, 8, maximum accepted beats per grant before forced rotation (>=1)
CW, 4, beat counter width; must hold MAX_BURST

Ports:
wr_clk  in  1  write-domain clock; same clock as the FIFO write side
wr_rstn  in  1  asynchronous, active-low reset
req_valid  in  NREQ  per-requester beat valid
req_data  in  NREQ*DW  packed beats; requester i uses bits [i*DW +: DW]
req_last  in  NREQ  marks the final beat of a burst
req_ready  out  NREQ  per-requester beat accepted; only the granted bit can be 1
fifo_wr_en  out  1  to FIFO wr_en
fifo_wr_data  out  DW  to FIFO wr_data
fifo_full  in  1  from FIFO full flag
grant_id  out  GW  index of the current or most recent owner
busy  out  1  1 while in BURST
forced_rot  out  1  one-cycle pulse when a grant ends on MAX_BURST rather than last

Behaviour:
- Reset (async, wr_rstn=0):
  - state=IDLE, grant_id=0, last_grant=NREQ-1, beat_cnt=0.
  - forced_rot=0, busy=0, fifo_wr_en=0, req_ready=0.
  - fifo_wr_data follows the req_data slice of grant_id (don't-care while fifo_wr_en=0).
- FSM states: IDLE, BURST.
- IDLE:
  - No writes; req_ready=0.
  - If any req_valid=1, pick the first set bit searching from last_grant+1 upward, mod NREQ.
  - Register that index into grant_id, set beat_cnt=0, and go to BURST on the next edge.
  - Arbitration latency is 1 cycle.
- BURST (g = grant_id):
  - fifo_wr_en = req_valid[g] & ~fifo_full (combinational).
  - req_ready[g] = ~fifo_full; all other ready bits are 0.
  - fifo_wr_data = req_data slice g.
  - A beat is accepted when req_valid[g] & ~fifo_full; each accepted beat increments beat_cnt.
  - Exit to IDLE when an accepted beat has req_last[g]=1, or when that beat makes beat_cnt equal MAX_BURST.
  - On exit, last_grant<=g and beat_cnt<=0.
  - forced_rot pulses (registered, the cycle after exit) only if the exit was on MAX_BURST and req_last[g] was 0.
- Both exit conditions on the same beat: the grant ends normally and forced_rot=0.
- Owner drops req_valid mid-burst: the grant is held and wr_en stays low. There are no idle-timeouts.
- fifo_full=1: no write, no ready, beat_cnt frozen. The requester must hold data/last stable while valid & ~ready. No beat may be lost or duplicated.
- beat_cnt counts accepted beats only. It never wraps, because the exit occurs at MAX_BURST.
- A requester deasserting valid while not granted is legal and is simply skipped.
- Reset mid-burst: the in-flight beat is abandoned immediately. After release, arbitration restarts with req0 highest priority.
- Sustained throughput is MAX_BURST beats per MAX_BURST+1 cycles with one requester always ready.

Decomposition:
- The shared defines file holds the FIFO data width and depth defines, from which DW derives. The state encodings IDLE=1'b0 and BURST=1'b1 are local constants.
- One sub-module is natural: rr_arbiter. It is purely combinational: it takes req[NREQ] and last_grant[GW] and returns gnt_idx[GW] and any_req. It is reused by the read side later.

Test Plan:
1. Reset held, all req_valid=1 -> fifo_wr_en=0, req_ready=0, busy=0, grant_id=0, forced_rot=0. After release, the first grant is req0.
2. Only req1 sends A1,A2,A3 (last on A3), fifo_full=0 -> 1 IDLE cycle, then fifo_wr_en=1 for 3 consecutive cycles with data A1,A2,A3 and grant_id=1, then busy=0.
3. All four requesters send single-beat bursts (last=1) continuously -> grant order 0,1,2,3,0,1,…; one write every 2 cycles.
4. req0 sends a 4-beat burst and fifo_full=1 for 2 cycles after beat 2 -> fifo_wr_en=0 and req_ready[0]=0 for those cycles. FIFO contents are exactly beats 1..4 in order.
5. req2 streams 12 beats with last only on beat 12 while req3 waits, MAX_BURST=8 -> req2 writes 8 beats, forced_rot pulses once, req3 is served, then req2 resumes with beats 9..12.
6. wr_rstn pulsed low during beat 3 of a req1 burst -> outputs reset asynchronously (fifo_wr_en=0 within the same cycle). After release, a pending req0 and req1 are granted req0 first.
